// File: rtl/pc_sequencer.sv
// Program counter owner and fetch sequencer: FETCH -> EXEC -> FETCH, stopping in HALT.
// Optional target alignment check enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             PCWre,
  input  logic [1:0]       PCSrc,
  input  logic [31:0]      signedImmediate,
  input  logic [25:0]      addr,
  input  logic [31:0]      regTarget,
  input  logic             halt,
  input  logic             imemAck,
  output logic             imemReq,
  output logic             instValid,
  output logic [31:0]      curPC,
  output logic [CNT_W-1:0] retired,
  output logic             halted,
  output logic             fetchErr,
  output logic             misalign
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               fetch_err_q, fetch_err_d;
  logic [31:0]        pc4;
  logic [31:0]        next_raw;
  logic [31:0]        next_pc;

  assign pc4 = pc_q + 32'd4;

  always_comb begin
    next_raw = pc4;
    case (PCSrc)
      2'b00:   next_raw = pc4;
      2'b01:   next_raw = pc4 + (signedImmediate << 2);
      2'b10:   next_raw = {pc4[31:28], addr, 2'b00};
      default: next_raw = regTarget;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign next_pc  = next_raw;
  assign misalign = misalign_q;
`else
  // Without the check, a register target is silently word-aligned.
  assign next_pc  = next_raw & ~32'h3;
  assign misalign = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      retired_q   <= '0;
      wait_q      <= '0;
      fetch_err_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      retired_q   <= retired_d;
      wait_q      <= wait_d;
      fetch_err_q <= fetch_err_d;
`ifdef PC_ALIGN_CHECK_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    retired_d   = retired_q;
    wait_d      = '0;
    fetch_err_d = fetch_err_q;
`ifdef PC_ALIGN_CHECK_EN
    misalign_d  = misalign_q;
`endif
    imemReq     = 1'b0;
    instValid   = 1'b0;
    halted      = 1'b0;

    case (state_q)
      S_FETCH: begin
        imemReq = 1'b1;
        // An ack arriving on the final allowed cycle still wins over the timeout.
        if (imemAck) begin
          state_d = S_EXEC;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          fetch_err_d = 1'b1;
          state_d     = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_EXEC: begin
        instValid = 1'b1;
        if (PCWre) begin
          retired_d = retired_q + CNT_W'(1);
          if (halt) begin
            state_d = S_HALT;
`ifdef PC_ALIGN_CHECK_EN
          end else if (next_pc[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = S_HALT;
`endif
          end else begin
            pc_d    = next_pc;
            state_d = S_FETCH;
          end
        end
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  assign curPC    = pc_q;
  assign retired  = retired_q;
  assign fetchErr = fetch_err_q;

endmodule
